// File: rtl/led_frame_receiver.sv
// led_frame_receiver
// Receives 16-bit frames from the LED shift-chain link (data, shift clock,
// active-low latch). All three serial lines are oversampled in the i_CLK
// domain and the frame is rebuilt in the driver's bit order (8..15 then 0..7).
// Optional feature: define LED_FRAME_RECEIVER_LENGTH_CHECK_EN to flag frames
// whose length is not exactly 16 bits on o_FrameErr instead of delivering them.

module led_frame_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_CLK,
    input  logic        i_RESET,
    input  logic        i_SerCLK,
    input  logic        i_SerData,
    input  logic        i_SerLatch,
    output logic [15:0] o_Data16,
    output logic        o_Valid,
    output logic        o_FrameErr,
    output logic [4:0]  o_BitCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OVER  = 2'd2
    } state_t;

    localparam logic [4:0] FULL_COUNT = 5'd16;
    localparam logic [4:0] OVER_COUNT = 5'd17;

    // Synchronizer chains; the last element of each is the usable sample.
    logic [SYNC_STAGES-1:0] sclk_sync_p0;
    logic [SYNC_STAGES-1:0] sdata_sync_p0;
    logic [SYNC_STAGES-1:0] slatch_sync_p0;
    logic                   sclk_prev_p1;

    logic sclk_s;
    logic sdata_s;
    logic slatch_s;
    logic sclk_event;

    state_t      state;
    state_t      state_next;
    logic [4:0]  bit_count;
    logic [4:0]  bit_count_next;
    logic [15:0] shadow;
    logic [15:0] shadow_next;
    logic [15:0] data_next;
    logic        valid_next;
    logic        err_next;
    logic [3:0]  bit_index;

    // Shift each serial line through its synchronizer chain.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            sclk_sync_p0   <= '0;
            sdata_sync_p0  <= '0;
            slatch_sync_p0 <= '0;
        end else begin
            sclk_sync_p0   <= {sclk_sync_p0[SYNC_STAGES-2:0],   i_SerCLK};
            sdata_sync_p0  <= {sdata_sync_p0[SYNC_STAGES-2:0],  i_SerData};
            slatch_sync_p0 <= {slatch_sync_p0[SYNC_STAGES-2:0], i_SerLatch};
        end
    end

    // Edge-history flop on the synchronized serial clock.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            sclk_prev_p1 <= 1'b0;
        end else begin
            sclk_prev_p1 <= sclk_s;
        end
    end

    assign sclk_s     = sclk_sync_p0[SYNC_STAGES-1];
    assign sdata_s    = sdata_sync_p0[SYNC_STAGES-1];
    assign slatch_s   = slatch_sync_p0[SYNC_STAGES-1];
    assign sclk_event = sclk_s & ~sclk_prev_p1;

    // The driver sends the high byte first, so bit k lands at index k XOR 8.
    assign bit_index = {~bit_count[3], bit_count[2:0]};

    // FSM state register.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, bit capture and frame-close decisions on each SCLK event.
    always_comb begin
        state_next     = state;
        bit_count_next = bit_count;
        shadow_next    = shadow;
        data_next      = o_Data16;
        valid_next     = 1'b0;
        err_next       = 1'b0;

        if (sclk_event) begin
            if (slatch_s) begin
                // Latch high: a data bit is on the line.
                case (state)
                    IDLE: begin
                        shadow_next[bit_index] = sdata_s;
                        bit_count_next         = bit_count + 5'd1;
                        state_next             = SHIFT;
                    end
                    SHIFT: begin
                        if (bit_count == FULL_COUNT) begin
                            // 17th bit: the frame is already too long, drop it.
                            bit_count_next = OVER_COUNT;
                            state_next     = OVER;
                        end else begin
                            shadow_next[bit_index] = sdata_s;
                            bit_count_next         = bit_count + 5'd1;
                        end
                    end
                    OVER: begin
                        bit_count_next = OVER_COUNT;
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end else begin
                // Latch low: close the frame; the data line is ignored here.
                if (bit_count == FULL_COUNT) begin
                    data_next  = shadow;
                    valid_next = 1'b1;
                end else begin
`ifdef LED_FRAME_RECEIVER_LENGTH_CHECK_EN
                    err_next = 1'b1;
`else
                    // Partial or overlong frames are delivered as captured.
                    if (bit_count != 5'd0) begin
                        data_next  = shadow;
                        valid_next = 1'b1;
                    end
`endif
                end
                state_next     = IDLE;
                bit_count_next = 5'd0;
                shadow_next    = 16'h0000;
            end
        end
    end

    // Frame assembly registers and the registered outputs.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            bit_count  <= 5'd0;
            shadow     <= 16'h0000;
            o_Data16   <= 16'h0000;
            o_Valid    <= 1'b0;
            o_FrameErr <= 1'b0;
        end else begin
            bit_count  <= bit_count_next;
            shadow     <= shadow_next;
            o_Data16   <= data_next;
            o_Valid    <= valid_next;
            o_FrameErr <= err_next;
        end
    end

    assign o_BitCount = bit_count;

endmodule

// File: tb/tb_led_frame_receiver.sv
// Testbench for led_frame_receiver: directed frames driven over the serial
// pins, expected words queued by the stimulus and matched by a monitor.

module tb_led_frame_receiver;

    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ser_clk;
    logic        ser_data;
    logic        ser_latch;
    logic [15:0] data16;
    logic        valid;
    logic        ferr;
    logic [4:0]  bcount;

    typedef struct packed {
        logic        err;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   phase    = 4;
    logic prev_out = 1'b0;

    led_frame_receiver #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .i_CLK      (clk),
        .i_RESET    (rst),
        .i_SerCLK   (ser_clk),
        .i_SerData  (ser_data),
        .i_SerLatch (ser_latch),
        .o_Data16   (data16),
        .o_Valid    (valid),
        .o_FrameErr (ferr),
        .o_BitCount (bcount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic err, input logic [15:0] d);
        exp_t e;
        e.err  = err;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One serial clock period: low phase then high phase, data/latch held.
    task automatic ser_cycle(input logic d, input logic l);
        ser_data  = d;
        ser_latch = l;
        ser_clk   = 1'b0;
        repeat (phase) @(negedge clk);
        ser_clk = 1'b1;
        repeat (phase) @(negedge clk);
    endtask

    task automatic ser_idle();
        ser_clk   = 1'b0;
        ser_latch = 1'b1;
        ser_data  = 1'b0;
        repeat (phase) @(negedge clk);
    endtask

    // Send n bits of word in driver order; bits past 16 are sent as 1.
    task automatic send_bits(input logic [15:0] word, input int n);
        for (int k = 0; k < n; k++) begin
            if (k < 16) ser_cycle(word[k ^ 8], 1'b1);
            else        ser_cycle(1'b1, 1'b1);
        end
    endtask

    task automatic send_latch();
        ser_cycle(1'b0, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a strobe.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst && (valid || ferr)) begin
                check("valid_and_err_together", {31'd0, valid & ferr}, 32'd0);
                check("consecutive_strobe", {31'd0, prev_out}, 32'd0);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe valid=%0b err=%0b data=0x%0h required=none",
                             valid, ferr, data16);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (ferr !== e.err) begin
                        failures++;
                        $display("FAIL strobe_kind err=%0b required=%0b", ferr, e.err);
                    end
                    if (!e.err) check("frame_data", {16'd0, data16}, {16'd0, e.data});
                end
            end
            prev_out = rst ? 1'b0 : (valid | ferr);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        rst       = 1'b1;
        ser_clk   = 1'b0;
        ser_data  = 1'b0;
        ser_latch = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", {16'd0, data16}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_err", {31'd0, ferr}, 32'd0);
        check("reset_bitcount", {27'd0, bcount}, 32'd0);
        rst = 1'b0;
        ser_idle();

        // Normal frame
        send_bits(16'hA55A, 16);
        check("normal_bitcount16", {27'd0, bcount}, 32'd16);
        push_exp(1'b0, 16'hA55A);
        send_latch();
        ser_idle();
        wait_drain("normal");
        check("normal_data", {16'd0, data16}, 32'h0000A55A);
        check("normal_bitcount0", {27'd0, bcount}, 32'd0);

        // Back-to-back frames
        push_exp(1'b0, 16'h1234);
        send_bits(16'h1234, 16);
        send_latch();
        push_exp(1'b0, 16'hFFFF);
        send_bits(16'hFFFF, 16);
        send_latch();
        ser_idle();
        wait_drain("b2b");
        check("b2b_data", {16'd0, data16}, 32'h0000FFFF);

        push_exp(1'b0, 16'h1234);
        send_bits(16'h1234, 16);
        send_latch();
        ser_idle();
        wait_drain("reload");

        // Short frame
        send_bits(16'hBEEF, 12);
        check("short_bitcount", {27'd0, bcount}, 32'd12);
`ifdef LED_FRAME_RECEIVER_LENGTH_CHECK_EN
        push_exp(1'b1, 16'h0000);
`else
        push_exp(1'b0, 16'hBE0F);
`endif
        send_latch();
        ser_idle();
        wait_drain("short");
`ifdef LED_FRAME_RECEIVER_LENGTH_CHECK_EN
        check("short_data_held", {16'd0, data16}, 32'h00001234);
`else
        check("short_data", {16'd0, data16}, 32'h0000BE0F);
`endif

        // Overrun
        send_bits(16'hC3A5, 20);
        check("over_bitcount", {27'd0, bcount}, 32'd17);
`ifdef LED_FRAME_RECEIVER_LENGTH_CHECK_EN
        push_exp(1'b1, 16'h0000);
`else
        push_exp(1'b0, 16'hC3A5);
`endif
        send_latch();
        ser_idle();
        wait_drain("over");
`ifdef LED_FRAME_RECEIVER_LENGTH_CHECK_EN
        check("over_data_held", {16'd0, data16}, 32'h00001234);
`else
        check("over_data", {16'd0, data16}, 32'h0000C3A5);
`endif
        check("over_bitcount0", {27'd0, bcount}, 32'd0);

        // Mid-frame asynchronous reset
        send_bits(16'h5A5A, 9);
        ser_clk = 1'b0;
        repeat (phase) @(negedge clk);
        check("prereset_bitcount", {27'd0, bcount}, 32'd9);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_data", {16'd0, data16}, 32'd0);
        check("async_reset_bitcount", {27'd0, bcount}, 32'd0);
        check("async_reset_valid", {31'd0, valid}, 32'd0);
        check("async_reset_err", {31'd0, ferr}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ser_idle();
        push_exp(1'b0, 16'h00FF);
        send_bits(16'h00FF, 16);
        send_latch();
        ser_idle();
        wait_drain("post_reset");
        check("post_reset_data", {16'd0, data16}, 32'h000000FF);

        // Minimum-phase stress
        phase = SYNC_STAGES + 1;
        for (int n = 0; n < 100; n++) begin
            w = 16'($urandom);
            push_exp(1'b0, w);
            send_bits(w, 16);
            send_latch();
        end
        ser_idle();
        wait_drain("stress");

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
